// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: arbiter state
// encoding, baud divisors at 50 MHz, and counter sizing helpers.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      WAIT_BUSY = 3'd2,
      SEND      = 3'd3,
      GAP       = 3'd4
   } arb_state_t;

   localparam int CLK_HZ           = 50_000_000;
   localparam int BAUD_DIV_4800    = CLK_HZ / 4800;
   localparam int BAUD_DIV_9600    = CLK_HZ / 9600;
   localparam int BAUD_DIV_19200   = CLK_HZ / 19200;
   localparam int BAUD_DIV_57600   = CLK_HZ / 57600;
   localparam int BAUD_DIV_115200  = CLK_HZ / 115200;

   // One bit time at the fastest supported rate is the shortest safe idle gap.
   localparam int DEFAULT_GAP_CYCLES = BAUD_DIV_115200;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int cnt_width(input int a, input int b);
      return $clog2(max_int(a, b) + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr,
// wrapping, as a one-hot grant plus the pointer just past the winner.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] next_ptr,
   output logic          valid
);

   localparam logic [N-1:0] LSB_ONE = {{(N-1){1'b0}}, 1'b1};

   logic [2*N-1:0] dbl_s;
   logic [2*N-1:0] gdbl_s;
   logic [N-1:0]   rot_s;
   logic [N-1:0]   first_s;
   int             off_s;
   int             sum_s;

   // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
   always_comb begin
      dbl_s   = {req, req} >> ptr;
      rot_s   = dbl_s[N-1:0];
      first_s = rot_s & (~rot_s + LSB_ONE);
      gdbl_s  = {first_s, first_s} << ptr;
      gnt     = gdbl_s[2*N-1:N];
      valid   = |req;
      off_s   = 0;
      for (int k = 0; k < N; k++) begin
         if (((first_s >> k) & LSB_ONE) != {N{1'b0}}) begin
            off_s = k;
         end else begin
            off_s = off_s;
         end
      end
      sum_s = int'(ptr) + off_s + 1;
      if (!valid) begin
         next_ptr = ptr;
      end else if (sum_s >= N) begin
         next_ptr = PW'(sum_s - N);
      end else begin
         next_ptr = PW'(sum_s);
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers with round-robin
// arbitration; define UART_ARB_PRIO_EN to give requester 0 strict priority.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int GAP_CYCLES    = DEFAULT_GAP_CYCLES,
   parameter int START_TIMEOUT = 1024
) (
   input  logic                 clk50,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [7:0]           tx_data,
   output logic                 tx_start,
   input  logic                 tx_busy,
   output logic                 busy,
   output logic                 err,
   input  logic                 err_clr
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = cnt_width(GAP_CYCLES, START_TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] TO_LAST  = CW'(START_TIMEOUT - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

   arb_state_t           state_r;
   logic [PW-1:0]        rr_ptr_r;
   logic [CW-1:0]        cnt_r;
   logic [NUM_REQ-1:0]   arb_req_s;
   logic [NUM_REQ-1:0]   arb_gnt_s;
   logic [PW-1:0]        arb_next_s;
   logic                 arb_valid_s;
   logic [NUM_REQ-1:0]   win_gnt_s;
   logic [PW-1:0]        win_next_s;
   logic [8*NUM_REQ-1:0] masked_s;
   logic [7:0]           win_data_s;
   logic                 timeout_s;

   // Requester 0 is taken out of the rotation when it has strict priority.
   always_comb begin
`ifdef UART_ARB_PRIO_EN
      arb_req_s = req & {{(NUM_REQ-1){1'b1}}, 1'b0};
`else
      arb_req_s = req;
`endif
   end

   rr_arbiter #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_rr (
      .req      (arb_req_s),
      .ptr      (rr_ptr_r),
      .gnt      (arb_gnt_s),
      .next_ptr (arb_next_s),
      .valid    (arb_valid_s)
   );

   // Final winner; a priority grant to requester 0 leaves the pointer alone.
   always_comb begin
`ifdef UART_ARB_PRIO_EN
      if (req[0]) begin
         win_gnt_s  = {{(NUM_REQ-1){1'b0}}, 1'b1};
         win_next_s = rr_ptr_r;
      end else begin
         win_gnt_s  = arb_gnt_s;
         win_next_s = arb_next_s;
      end
`else
      win_gnt_s  = arb_gnt_s;
      win_next_s = arb_next_s;
`endif
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_mask
      assign masked_s[8*g +: 8] = req_data[8*g +: 8] & {8{win_gnt_s[g]}};
   end

   // One-hot mux of the winning requester's byte.
   always_comb begin
      win_data_s = 8'h00;
      for (int k = 0; k < NUM_REQ; k++) begin
         win_data_s = win_data_s | 8'(masked_s >> (8 * k));
      end
   end

   assign timeout_s = (state_r == WAIT_BUSY) && !tx_busy && (cnt_r == TO_LAST);

   // Transmit sequencer with registered outputs.
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         rr_ptr_r <= {PW{1'b0}};
         cnt_r    <= CNT_ZERO;
         gnt      <= {NUM_REQ{1'b0}};
         tx_data  <= 8'h00;
         tx_start <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
      end else begin
         // Clear wins over a coincident timeout; that timeout is dropped.
         err <= err_clr ? 1'b0 : (err | timeout_s);
         case (state_r)
            IDLE: begin
               tx_start <= 1'b0;
               if (|req) begin
                  gnt      <= win_gnt_s;
                  tx_data  <= win_data_s;
                  rr_ptr_r <= win_next_s;
                  busy     <= 1'b1;
                  state_r  <= START;
               end else begin
                  gnt <= {NUM_REQ{1'b0}};
               end
            end
            START: begin
               gnt      <= {NUM_REQ{1'b0}};
               tx_start <= 1'b1;
               cnt_r    <= CNT_ZERO;
               state_r  <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               tx_start <= 1'b0;
               if (tx_busy) begin
                  state_r <= SEND;
               end else if (timeout_s) begin
                  cnt_r   <= CNT_ZERO;
                  state_r <= GAP;
               end else begin
                  cnt_r <= (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
               end
            end
            SEND: begin
               if (!tx_busy) begin
                  cnt_r   <= CNT_ZERO;
                  state_r <= GAP;
               end else begin
                  state_r <= SEND;
               end
            end
            GAP: begin
               if (cnt_r >= GAP_LAST) begin
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  cnt_r <= (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
               end
            end
            default: begin
               gnt      <= {NUM_REQ{1'b0}};
               tx_start <= 1'b0;
               busy     <= 1'b0;
               state_r  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: producers are byte queues, the
// transmitter is a behavioural model, grants are predicted from queue state.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int NUM_REQ       = 4;
   localparam int GAP_CYCLES    = 12;
   localparam int START_TIMEOUT = 40;

   logic                 clk50;
   logic                 rst_n;
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   gnt;
   logic [7:0]           tx_data;
   logic                 tx_start;
   logic                 tx_busy;
   logic                 busy;
   logic                 err;
   logic                 err_clr;

   uart_tx_arbiter #(
      .NUM_REQ       (NUM_REQ),
      .GAP_CYCLES    (GAP_CYCLES),
      .START_TIMEOUT (START_TIMEOUT)
   ) dut (
      .clk50    (clk50),
      .rst_n    (rst_n),
      .req      (req),
      .req_data (req_data),
      .gnt      (gnt),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_busy  (tx_busy),
      .busy     (busy),
      .err      (err),
      .err_clr  (err_clr)
   );

   initial clk50 = 1'b0;
   always #10 clk50 = ~clk50;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] q [NUM_REQ][$];
   int   m_ptr = 0;
   int   cyc = 0;
   int   last_fall = -100000;
   int   start_cyc = 0;
   int   frames = 0;
   int   grants = 0;
   int   n_start = 0;
   int   lat_cnt = 0;
   int   busy_cnt = 0;
   int   busy_len = 5;
   bit   tx_dead = 1'b0;
   bit   pend_start = 1'b0;
   logic [7:0] exp_data = 8'h00;
   int   dut_log[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Round-robin rule over the producers that currently hold data.
   function automatic int pick();
`ifdef UART_ARB_PRIO_EN
      if (q[0].size() > 0) return 0;
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = (m_ptr + k) % NUM_REQ;
`ifdef UART_ARB_PRIO_EN
         if (idx == 0) continue;
`endif
         if (q[idx].size() > 0) begin
            m_ptr = (idx + 1) % NUM_REQ;
            return idx;
         end
      end
      return -1;
   endfunction

   task automatic drive_reqs();
      for (int i = 0; i < NUM_REQ; i++) begin
         req[i] = (q[i].size() > 0);
         req_data[8*i +: 8] = (q[i].size() > 0) ? q[i][0] : 8'h00;
      end
   endtask

   task automatic push(input int r, input logic [7:0] b);
      q[r].push_back(b);
      drive_reqs();
   endtask

   task automatic step();
      int w;
      @(negedge clk50);
      cyc++;
      if (rst_n) begin
         chk("tx_start", {31'd0, tx_start}, {31'd0, pend_start});
         if (tx_start) begin
            chk("tx_data", {24'd0, tx_data}, {24'd0, exp_data});
            chk("busy_at_start", {31'd0, busy}, 32'd1);
            chk("gap_ok", {31'd0, ((cyc - last_fall) >= GAP_CYCLES)}, 32'd1);
            n_start++;
            start_cyc = cyc;
            if (!tx_dead) lat_cnt = 2;
         end
         pend_start = 1'b0;
         if (gnt != '0) begin
            for (int k = 0; k < NUM_REQ; k++) if (gnt[k]) dut_log.push_back(k);
            w = pick();
            if (w < 0) begin
               chk("gnt_spurious", {28'd0, gnt}, 32'd0);
            end else begin
               chk("gnt", {28'd0, gnt}, 32'd1 << w);
               exp_data = q[w].pop_front();
               grants++;
               pend_start = 1'b1;
            end
         end
      end
      if (tx_busy) begin
         busy_cnt--;
         if (busy_cnt <= 0) begin
            chk("tx_data_hold", {24'd0, tx_data}, {24'd0, exp_data});
            tx_busy = 1'b0;
            last_fall = cyc;
         end
      end else if (lat_cnt > 0) begin
         lat_cnt--;
         if (lat_cnt == 0) begin
            tx_busy = 1'b1;
            busy_cnt = busy_len;
            frames++;
         end
      end
      drive_reqs();
   endtask

   task automatic drain(input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 &&
             q[3].size() == 0 && !busy && !tx_busy && !pend_start && lat_cnt == 0) begin
            done = 1'b1;
            break;
         end
         step();
      end
      chk(tag, {31'd0, done}, 32'd1);
   endtask

   initial begin
      int s0;
      int f0;
      int exp_order[5];
      rst_n = 1'b0;
      err_clr = 1'b0;
      tx_busy = 1'b0;
      drive_reqs();
      repeat (3) step();
      chk("rst_gnt", {28'd0, gnt}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      rst_n = 1'b1;
      step();

      // All four requesting, long frames: order follows rotation from 0.
      busy_len = 100;
      dut_log.delete();
      f0 = frames;
      push(0, 8'hA0); push(0, 8'hA1); push(1, 8'hB1); push(2, 8'hC2); push(3, 8'hD3);
      drain("drain_all4");
`ifdef UART_ARB_PRIO_EN
      exp_order = '{0, 0, 1, 2, 3};
`else
      exp_order = '{0, 1, 2, 3, 0};
`endif
      chk("all4_count", dut_log.size(), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < dut_log.size()) chk("all4_order", dut_log[i], exp_order[i]);
      end
      chk("all4_frames", frames - f0, 32'd5);

      // Single request: one-cycle latency to gnt, one more to tx_start.
      busy_len = 8;
      push(2, 8'hA5);
      step();
      chk("lat_gnt", {28'd0, gnt}, 32'b0100);
      chk("lat_data", {24'd0, tx_data}, 32'hA5);
      step();
      chk("lat_start", {31'd0, tx_start}, 32'd1);
      drain("drain_single");

      // Repeated identical bytes are each framed.
      s0 = n_start;
      f0 = frames;
      push(1, 8'h55); push(1, 8'h55);
      drain("drain_repeat");
      chk("repeat_starts", n_start - s0, 32'd2);
      chk("repeat_frames", frames - f0, 32'd2);

      // Transmitter never responds: err after exactly START_TIMEOUT cycles.
      tx_dead = 1'b1;
      s0 = n_start;
      push(2, 8'h3C);
      for (int i = 0; i < 200 && !err; i++) step();
      chk("err_set", {31'd0, err}, 32'd1);
      chk("timeout_cycles", cyc - start_cyc, START_TIMEOUT);
      drain("drain_timeout");
      tx_dead = 1'b0;
      push(3, 8'hC3);
      drain("drain_after_to");
      chk("err_sticky", {31'd0, err}, 32'd1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("err_clr", {31'd0, err}, 32'd0);

      // Clear coincident with a new timeout: clear wins, event is lost.
      tx_dead = 1'b1;
      s0 = n_start;
      push(1, 8'h11);
      for (int i = 0; i < 50 && n_start == s0; i++) step();
      for (int i = 0; i < 200 && cyc < start_cyc + START_TIMEOUT - 1; i++) step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("err_clr_prio", {31'd0, err}, 32'd0);
      step();
      chk("err_lost", {31'd0, err}, 32'd0);
      drain("drain_clr_prio");
      tx_dead = 1'b0;

      // Reset in SEND: frame abandoned, pointer back to 0.
      busy_len = 30;
      push(2, 8'h77);
      for (int i = 0; i < 50 && !tx_busy; i++) step();
      step();
      push(1, 8'h81); push(3, 8'h83);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_gnt", {28'd0, gnt}, 32'd0);
      chk("arst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("arst_tx_start", {31'd0, tx_start}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_err", {31'd0, err}, 32'd0);
      m_ptr = 0;
      tx_busy = 1'b0;
      lat_cnt = 0;
      busy_cnt = 0;
      pend_start = 1'b0;
      dut_log.delete();
      repeat (3) step();
      rst_n = 1'b1;
      drain("drain_rst");
      chk("rst_grants", dut_log.size(), 32'd2);
      if (dut_log.size() >= 2) begin
         chk("rst_first", dut_log[0], 32'd1);
         chk("rst_second", dut_log[1], 32'd3);
      end

      // Randomized traffic against the queue model.
      for (int it = 0; it < 40; it++) begin
         int nb;
         nb = $urandom_range(1, 3);
         for (int j = 0; j < nb; j++) begin
            push($urandom_range(0, NUM_REQ - 1), 8'($urandom_range(0, 255)));
         end
         busy_len = $urandom_range(1, 30);
         repeat ($urandom_range(0, 60)) step();
      end
      drain("drain_random");
      chk("gnt_per_start", grants, n_start);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
